// File: rtl/mem_stage_ctrl_if.sv
// Datapath-to-dcache request/response bundle for the MEM stage.
// master = MEM-stage controller, slave = cache.
interface mem_stage_ctrl_if #(
   parameter int unsigned WORD_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] dmemaddr;
   logic [WORD_W-1:0] dmemstore;
   logic              dhit;
   logic [WORD_W-1:0] dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage dcache request controller: one outstanding request, stalls until dhit,
// captures load data for MEM/WB, latches processor halt, optional request timeout.
module mem_stage_ctrl #(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic              advance,
   input  logic              dREN_i,
   input  logic              dWEN_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              halt_i,
   mem_stage_ctrl_if.master  dif,
   output logic [WORD_W-1:0] dload_o,
   output logic              mem_stall,
   output logic              misalign_o,
   output logic              err_o,
   output logic              halt_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, HALTED} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] addr_q, wdata_q;
   logic              we_q;
   logic              latch;
   logic              flush_pend_q, flush_pend_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] dload_q, dload_d;
   logic              err_q, err_d;
   logic              req;

   assign req = dREN_i | dWEN_i;

   always_comb begin
      state_d       = state_q;
      latch         = 1'b0;
      flush_pend_d  = flush_pend_q;
      cnt_d         = cnt_q;
      dload_d       = dload_q;
      err_d         = err_q;
      mem_stall     = 1'b0;
      misalign_o    = 1'b0;
      dif.dmemREN   = 1'b0;
      dif.dmemWEN   = 1'b0;
      dif.dmemaddr  = '0;
      dif.dmemstore = '0;

      unique case (state_q)
         IDLE: begin
            if (!flush) begin
               if (req) begin
                  if (addr_i[1:0] != 2'b00) begin
                     misalign_o = 1'b1;
                  end else begin
                     latch        = 1'b1;
                     mem_stall    = 1'b1;
                     cnt_d        = '0;
                     flush_pend_d = 1'b0;
                     state_d      = BUSY;
                  end
               end else if (halt_i) begin
                  state_d = HALTED;
               end
            end
         end
         BUSY: begin
            mem_stall     = 1'b1;
            dif.dmemREN   = ~we_q;
            dif.dmemWEN   = we_q;
            dif.dmemaddr  = addr_q;
            dif.dmemstore = wdata_q;
            // A flush cannot cancel an in-flight cache access; remember it and drop the result.
            if (flush) flush_pend_d = 1'b1;
            if (dif.dhit) begin
               if (flush_pend_q || flush) begin
                  state_d = IDLE;
               end else begin
                  if (!we_q) dload_d = dif.dmemload;
                  state_d = DONE;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               err_d   = 1'b1;
               dload_d = WORD_W'(32'hDEAD_BEEF);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (advance || flush) state_d = IDLE;
         end
         HALTED: begin
            mem_stall = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         flush_pend_q <= 1'b0;
         cnt_q        <= '0;
         dload_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         cnt_q        <= cnt_d;
         dload_q      <= dload_d;
         err_q        <= err_d;
         if (latch) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= dWEN_i;
         end
      end
   end

   assign dload_o = dload_q;
   assign err_o   = err_q;
   assign halt_o  = (state_q == HALTED);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus pushes expected issue/complete/misalign
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage_ctrl;
   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          RST, flush, advance, dREN_i, dWEN_i, halt_i;
   logic [W-1:0]  addr_i, wdata_i, dload_o;
   logic          mem_stall, misalign_o, err_o, halt_o;

   mem_stage_ctrl_if #(.WORD_W(W)) dif ();

   mem_stage_ctrl #(.WORD_W(W), .TIMEOUT(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .flush      (flush),
      .advance    (advance),
      .dREN_i     (dREN_i),
      .dWEN_i     (dWEN_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .halt_i     (halt_i),
      .dif        (dif),
      .dload_o    (dload_o),
      .mem_stall  (mem_stall),
      .misalign_o (misalign_o),
      .err_o      (err_o),
      .halt_o     (halt_o)
   );

   always #5 CLK = ~CLK;

   // kind: 0 = request issued, 1 = request finished, 2 = misalign pulse
   typedef struct {
      int         kind;
      logic       we;
      logic [31:0] addr;
      logic [31:0] data;
      int         len;
      logic       err;
      logic [31:0] dload;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: DUT event with empty scoreboard", name);
   endtask

   task automatic push_exp(input int kind, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input int len, input logic err, input logic [31:0] dl);
      exp_t e;
      e.kind = kind; e.we = we; e.addr = a; e.data = d; e.len = len; e.err = err; e.dload = dl;
      sb.push_back(e);
   endtask

   // Monitor
   initial begin : monitor
      logic prev_en;
      logic en;
      int   len;
      exp_t e;
      prev_en = 1'b0;
      len     = 0;
      forever begin
         @(negedge CLK);
         en = dif.dmemREN | dif.dmemWEN;
         if (en && !prev_en) begin
            if (sb.size() == 0) unexpected("issue");
            else begin
               e = sb.pop_front();
               chk("issue_kind", e.kind, 0);
               chk("issue_wen", dif.dmemWEN, e.we);
               chk("issue_ren", dif.dmemREN, !e.we);
               chk("issue_addr", dif.dmemaddr, e.addr);
               if (e.we) chk("issue_store", dif.dmemstore, e.data);
            end
         end
         if (en) len++;
         if (!en && prev_en) begin
            if (sb.size() == 0) unexpected("complete");
            else begin
               e = sb.pop_front();
               chk("done_kind", e.kind, 1);
               chk("done_en_cycles", len, e.len);
               chk("done_dload", dload_o, e.dload);
               chk("done_err", err_o, e.err);
               chk("done_stall", mem_stall, 0);
            end
            len = 0;
         end
         if (misalign_o) begin
            if (sb.size() == 0) unexpected("misalign");
            else begin
               e = sb.pop_front();
               chk("mis_kind", e.kind, 2);
               chk("mis_addr", addr_i, e.addr);
               chk("mis_stall", mem_stall, 0);
            end
         end
         prev_en = en;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One request: ncyc cycles driven after issue, dhit on cycle hit_at, flush on flush_at,
   // then hold cycles with advance low before advancing.
   task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input int ncyc, input int hit_at, input logic [31:0] ld,
                          input int flush_at, input int hold,
                          input int exp_len, input logic exp_err, input logic [31:0] exp_dl);
      push_exp(0, we, a, d, 0, 1'b0, 32'h0);
      push_exp(1, we, a, d, exp_len, exp_err, exp_dl);
      dREN_i = !we; dWEN_i = we; addr_i = a; wdata_i = d;
      #1;
      chk("req_stall_comb", mem_stall, 1);
      step();
      chk("issue_latency", dif.dmemREN | dif.dmemWEN, 1);
      for (int c = 1; c <= ncyc; c++) begin
         if (c == flush_at) begin
            flush = 1'b1; dREN_i = 1'b0; dWEN_i = 1'b0;
         end
         if (c == hit_at) begin
            dif.dhit = 1'b1; dif.dmemload = ld;
         end
         step();
         dif.dhit = 1'b0; dif.dmemload = 32'h0; flush = 1'b0;
      end
      repeat (hold) step();
      advance = 1'b1; dREN_i = 1'b0; dWEN_i = 1'b0;
      step();
      advance = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      RST = 1'b1; flush = 1'b0; advance = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0; halt_i = 1'b0;
      addr_i = '0; wdata_i = '0; dif.dhit = 1'b0; dif.dmemload = '0;
      repeat (2) step();
      RST = 1'b0;
      chk("rst_dload", dload_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_halt", halt_o, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_misalign", misalign_o, 0);
      chk("rst_enables", {dif.dmemREN, dif.dmemWEN}, 0);
      step();

      // Load, dhit on 3rd busy cycle
      run_req(1'b0, 32'h100, 32'h0, 3, 3, 32'hCAFE_F00D, 0, 0, 3, 1'b0, 32'hCAFE_F00D);
      // Store, dhit on 1st busy cycle, DONE held 5 cycles without re-issue
      run_req(1'b1, 32'h204, 32'h1234_5678, 1, 1, 32'hFFFF_FFFF, 0, 5, 1, 1'b0, 32'hCAFE_F00D);

      // Misaligned load
      push_exp(2, 1'b0, 32'h102, 32'h0, 0, 1'b0, 32'h0);
      dREN_i = 1'b1; addr_i = 32'h102;
      step();
      dREN_i = 1'b0;
      step();

      // Flush at 2nd busy cycle, dhit at 4th: result discarded
      run_req(1'b0, 32'h300, 32'h0, 4, 4, 32'h5555_AAAA, 2, 0, 4, 1'b0, 32'hCAFE_F00D);

      // Timeout after 8 busy cycles
      run_req(1'b0, 32'h400, 32'h0, 12, 0, 32'h0, 0, 0, 8, 1'b1, 32'hDEAD_BEEF);

      // Halt
      halt_i = 1'b1;
      #1;
      chk("halt_not_yet", halt_o, 0);
      step();
      halt_i = 1'b0;
      chk("halt_set", halt_o, 1);
      chk("halt_stall", mem_stall, 1);
      for (int i = 0; i < 3; i++) begin
         dREN_i = 1'b1; addr_i = 32'h40;
         step();
         dREN_i = 1'b0;
         step();
      end
      chk("halt_sticky", halt_o, 1);
      chk("halt_enables", {dif.dmemREN, dif.dmemWEN}, 0);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("rst2_halt", halt_o, 0);
      chk("rst2_err", err_o, 0);
      chk("rst2_dload", dload_o, 0);
      chk("rst2_stall", mem_stall, 0);

      repeat (3) step();
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
